// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control path. The hazard controller
// and the pipeline latches both use this package.
//   latch_ctrl_e : per-latch command (load new data, hold, or flush to bubble)
//   hz_state_e   : hazard controller state encoding
//   MW_TIMEOUT   : consecutive memory-wait cycles that raise the timeout flag
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Latch command. 2'b11 is unused and is never driven by the controller.
    typedef enum logic [1:0] {
        LATCH_LOAD  = 2'b00,
        LATCH_HOLD  = 2'b01,
        LATCH_FLUSH = 2'b10
    } latch_ctrl_e;

    // Hazard controller states.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_MWAIT = 2'b01,
        ST_REDIR = 2'b10
    } hz_state_e;

    localparam logic [7:0] MW_TIMEOUT = 8'd255;

endpackage

// File: rtl/sat_counter16.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
//   clk     : clock, counts on the rising edge
//   rst_n   : asynchronous active-low clear
//   i_inc   : count one event this cycle
//   o_count : current count
// ---------------------------------------------------------------------------
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    // Increment on request, but once all ones the count stays there so a
    // long-running statistic never wraps back to a small value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller. Decides every cycle, combinationally, what each
// pipeline latch and the PC do, resolving memory wait > jump > load-use >
// icache miss.
//   clk, rst               : clock, asynchronous active-low reset
//   id_src_x/y, id_use_x/y : ID-stage source registers and their use flags
//   ex_load, ex_dst        : EX is a load, and its destination register
//   ex_jmp                 : EX resolves a taken jump
//   mm_req, dc_ready       : MM data-cache access and its completion
//   ic_ready               : instruction cache output valid
//   ctrl_ifid..ctrl_mmwb   : latch commands (LOAD/HOLD/FLUSH)
//   pc_en, pc_sel_jmp      : PC advance, PC loads jump target
//   mw_err                 : sticky memory-wait timeout
//   stall_cnt, jmp_cnt     : saturating stall-cycle and jump counters
// ---------------------------------------------------------------------------
module hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src_x,
    input  logic [3:0]  id_src_y,
    input  logic        id_use_x,
    input  logic        id_use_y,
    input  logic        ex_load,
    input  logic [3:0]  ex_dst,
    input  logic        ex_jmp,
    input  logic        mm_req,
    input  logic        dc_ready,
    input  logic        ic_ready,
    output logic [1:0]  ctrl_ifid,
    output logic [1:0]  ctrl_idex,
    output logic [1:0]  ctrl_exmm,
    output logic [1:0]  ctrl_mmwb,
    output logic        pc_en,
    output logic        pc_sel_jmp,
    output logic        mw_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] jmp_cnt
);

    hz_state_e   r_state;
    hz_state_e   w_next;
    latch_ctrl_e w_ifid;
    latch_ctrl_e w_idex;
    latch_ctrl_e w_exmm;
    latch_ctrl_e w_mmwb;
    logic        w_pc_en;
    logic        w_pc_sel_jmp;
    logic        w_jmp_acc;
    logic        w_waiting;
    logic        w_mem_wait;
    logic        w_load_use;
    logic [7:0]  r_mw_cnt;
    logic        r_mw_err;

    // Once in MWAIT we keep waiting until the cache reports completion, even
    // if mm_req drops, because MM is frozen on the outstanding access.
    assign w_mem_wait = (mm_req || (r_state == ST_MWAIT)) && !dc_ready;

    assign w_load_use = ex_load &&
                        ((id_use_x && (id_src_x == ex_dst)) ||
                         (id_use_y && (id_src_y == ex_dst)));

    // State register. Reset drops us straight back to RUN from anywhere,
    // so the first edge after release always starts from a clean pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and latch control. Outputs are combinational so the latches
    // act on them in the same cycle. While in reset every latch is flushed
    // and the PC is frozen. A jump seen during a memory wait is simply
    // ignored: EX is held, so the jump is presented again once the wait ends.
    // Leaving MWAIT without a jump loads everything regardless of the other
    // hazards, since the pipeline resumes from exactly where it froze.
    always_comb begin
        w_next       = r_state;
        w_ifid       = LATCH_LOAD;
        w_idex       = LATCH_LOAD;
        w_exmm       = LATCH_LOAD;
        w_mmwb       = LATCH_LOAD;
        w_pc_en      = 1'b1;
        w_pc_sel_jmp = 1'b0;
        w_jmp_acc    = 1'b0;
        w_waiting    = 1'b0;

        if (!rst) begin
            w_next  = ST_RUN;
            w_ifid  = LATCH_FLUSH;
            w_idex  = LATCH_FLUSH;
            w_exmm  = LATCH_FLUSH;
            w_mmwb  = LATCH_FLUSH;
            w_pc_en = 1'b0;
        end else if (w_mem_wait) begin
            w_next    = ST_MWAIT;
            w_ifid    = LATCH_HOLD;
            w_idex    = LATCH_HOLD;
            w_exmm    = LATCH_HOLD;
            w_mmwb    = LATCH_FLUSH;
            w_pc_en   = 1'b0;
            w_waiting = 1'b1;
        end else if (ex_jmp) begin
            w_next       = ST_REDIR;
            w_ifid       = LATCH_FLUSH;
            w_idex       = LATCH_FLUSH;
            w_pc_sel_jmp = 1'b1;
            w_jmp_acc    = 1'b1;
        end else if (r_state == ST_MWAIT) begin
            w_next = ST_RUN;
        end else begin
            if (ic_ready) begin
                w_next = ST_RUN;
            end
            if (w_load_use) begin
                w_ifid  = LATCH_HOLD;
                w_idex  = LATCH_FLUSH;
                w_pc_en = 1'b0;
            end else if (!ic_ready) begin
                w_ifid  = LATCH_FLUSH;
                w_pc_en = 1'b0;
            end
        end
    end

    // Memory-wait watchdog. Counts consecutive wait cycles; the flag is set
    // on the edge where the count reaches MW_TIMEOUT and then stays set until
    // reset. It only reports, it never changes the stall behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mw_cnt <= '0;
            r_mw_err <= 1'b0;
        end else if (w_waiting) begin
            if (r_mw_cnt != MW_TIMEOUT) begin
                r_mw_cnt <= r_mw_cnt + 8'd1;
            end
            if (r_mw_cnt >= (MW_TIMEOUT - 8'd1)) begin
                r_mw_err <= 1'b1;
            end
        end else begin
            r_mw_cnt <= '0;
        end
    end

    sat_counter16 u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (!w_pc_en),
        .o_count (stall_cnt)
    );

    sat_counter16 u_jmp_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_jmp_acc),
        .o_count (jmp_cnt)
    );

    assign ctrl_ifid  = w_ifid;
    assign ctrl_idex  = w_idex;
    assign ctrl_exmm  = w_exmm;
    assign ctrl_mmwb  = w_mmwb;
    assign pc_en      = w_pc_en;
    assign pc_sel_jmp = w_pc_sel_jmp;
    assign mw_err     = r_mw_err;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk        in   1   pipeline clock; all state changes on the rising edge.
- rst        in   1   asynchronous, active-low reset.
- id_src_x   in   4   ID-stage source register X.
- id_src_y   in   4   ID-stage source register Y.
- id_use_x   in   1   ID instruction reads X.
- id_use_y   in   1   ID instruction reads Y.
- ex_load    in   1   EX instruction is a memory read.
- ex_dst     in   4   EX destination register.
- ex_jmp     in   1   EX resolves a taken jump this cycle.
- mm_req     in   1   MM instruction accesses data cache.
- dc_ready   in   1   data cache completes the MM access this cycle.
- ic_ready   in   1   instruction cache output is valid this cycle.
- ctrl_ifid  out  2   latch control, IF/ID.
- ctrl_idex  out  2   latch control, ID/EX.
- ctrl_exmm  out  2   latch control, EX/MM.
- ctrl_mmwb  out  2   latch control, MM/WB.
- pc_en      out  1   PC register advances.
- pc_sel_jmp out  1   PC loads the jump target.
- mw_err     out  1   sticky memory-wait timeout flag.
- stall_cnt  out  16  saturating count of cycles with pc_en=0.
- jmp_cnt    out  16  saturating count of accepted jumps.
REQ-002 SHALL encode latch control as LOAD=2'b00, HOLD=2'b01, FLUSH=2'b10 (bubble); 2'b11 is never driven.

Function
REQ-003 SHALL implement a state machine with states RUN, MWAIT and REDIR, registered on clk; outputs are combinational from state and inputs, so the latches see them in the same cycle.
REQ-004 Within a cycle, SHALL resolve conditions in priority order: memory wait, then jump, then load-use, then icache miss.
REQ-005 RUN with no hazard SHALL drive:
- all ctrl_* = LOAD
- pc_en = 1
- pc_sel_jmp = 0
REQ-006 Memory wait, taken when mm_req=1 and dc_ready=0 in any state:
- ctrl_ifid, ctrl_idex, ctrl_exmm = HOLD
- ctrl_mmwb = FLUSH
- pc_en = 0
- next state MWAIT
REQ-007 MWAIT SHALL repeat the REQ-006 outputs while dc_ready=0.
- When dc_ready=1, all ctrl_* = LOAD and pc_en=1.
- Next state RUN, or REDIR if ex_jmp=1 in that cycle; the jump then follows REQ-008.
REQ-008 A jump (ex_jmp=1, not overridden by a memory wait) SHALL drive:
- ctrl_ifid = FLUSH, ctrl_idex = FLUSH
- ctrl_exmm = LOAD, ctrl_mmwb = LOAD
- pc_en = 1, pc_sel_jmp = 1
- next state REDIR
- jmp_cnt increments.
REQ-009 A jump occurring during a memory wait SHALL be ignored; EX holds the jump, so it is re-presented after the wait.
REQ-010 REDIR while ic_ready=0 SHALL drive:
- ctrl_ifid = FLUSH
- all other ctrl_* = LOAD
- pc_en = 0
- When ic_ready=1, behave as RUN and move to RUN.
REQ-011 A load-use hazard is ex_load=1 and ((id_use_x and id_src_x==ex_dst) or (id_use_y and id_src_y==ex_dst)). In RUN it SHALL drive:
- ctrl_ifid = HOLD
- ctrl_idex = FLUSH
- ctrl_exmm, ctrl_mmwb = LOAD
- pc_en = 0
- Duration is exactly one cycle; no state change.
REQ-012 An icache miss in RUN (ic_ready=0, no higher-priority condition) SHALL drive:
- ctrl_ifid = FLUSH
- all other ctrl_* = LOAD
- pc_en = 0
REQ-013 SHALL count consecutive MWAIT cycles in an 8-bit counter, cleared on leaving MWAIT.
- On reaching 255, mw_err sets and stays set until reset.
- Stall behaviour is unchanged.
REQ-014 stall_cnt and jmp_cnt SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-015 While rst=0, SHALL hold:
- state = RUN
- all counters = 0
- mw_err = 0
- all ctrl_* = FLUSH
- pc_en = 0
- pc_sel_jmp = 0
REQ-016 SHALL take effect immediately on rst assertion, including mid-MWAIT or mid-REDIR; after release, the first rising edge operates from RUN.

Structure
REQ-017 SHALL place the LOAD/HOLD/FLUSH constants and the state encodings in the shared package pipe_ctrl_pkg, which is also used by the pipeline latch.
REQ-018 SHALL implement stall_cnt and jmp_cnt with one sub-module, sat_counter16, instantiated twice.

Verification
REQ-019 Bench SHALL cover:
- ex_load=1, ex_dst=5, id_use_x=1, id_src_x=5 -> one cycle of ifid=HOLD, idex=FLUSH, pc_en=0; stall_cnt=1.
- ex_jmp=1 with ic_ready=0 for 2 cycles after -> cycle 0: ifid=idex=FLUSH, pc_sel_jmp=1; cycles 1-2: ifid=FLUSH, pc_en=0; cycle 3: RUN; jmp_cnt=1.
- mm_req=1, dc_ready=0 for 3 cycles, with ex_jmp=1 throughout -> 3 cycles ifid/idex/exmm=HOLD, mmwb=FLUSH; the jump is accepted in the dc_ready cycle.
- mm_req=1, dc_ready=0 for 300 cycles -> mw_err=1 from cycle 255 onward; outputs still MWAIT.
- stall_cnt preloaded via 65 540 stall cycles -> reads 16'hFFFF.
- rst=0 asserted mid-MWAIT -> all ctrl_* immediately FLUSH, pc_en=0; after release, state RUN.
